food_placer: RTL and testbench

//  Consumes the 8-bit pseudo-random position code from the random generator and picks the next food cell.

---
 rtl/food_placer_if.sv | 27 ++
 rtl/food_placer.sv | 160 ++++++++++++++++
 tb/tb_food_placer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/food_placer_if.sv
// Handshake bundle between the food placer, the game FSM / random source,
// and the snake body position RAM.
interface food_placer_if #(
    parameter int unsigned MAX_LEN = 32
);
    localparam int unsigned AW = $clog2(MAX_LEN);

    logic [7:0]    rnd_num;
    logic          place_req;
    logic [5:0]    snake_len;
    logic [AW-1:0] body_rd_addr;
    logic [7:0]    body_rd_data;
    logic [7:0]    food_pos;
    logic          food_valid;
    logic          busy;
    logic          place_fail;

    modport master (
        output rnd_num, place_req, snake_len, body_rd_data,
        input  body_rd_addr, food_pos, food_valid, busy, place_fail
    );

    modport slave (
        input  rnd_num, place_req, snake_len, body_rd_data,
        output body_rd_addr, food_pos, food_valid, busy, place_fail
    );
endinterface

// File: rtl/food_placer.sv
// Picks a food cell from the random code stream, rejecting off-board codes
// and codes that land on any snake body segment.
module food_placer #(
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned MAX_RETRY = 16
) (
    input  logic          clk,
    input  logic          rst,
    food_placer_if.slave  bus
);
    localparam int unsigned AW = $clog2(MAX_LEN);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned RW = $clog2(MAX_RETRY) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SCAN,
        TAIL,
        DONE
    } state_t;

    state_t        state_q,      state_d;
    logic [LW-1:0] len_q,        len_d;
    logic [RW-1:0] retry_q,      retry_d;
    logic [7:0]    cand_q,       cand_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic          cmp_v_q,      cmp_v_d;
    logic [7:0]    food_pos_q,   food_pos_d;
    logic          food_valid_q, food_valid_d;
    logic          busy_q,       busy_d;
    logic          place_fail_q, place_fail_d;

    logic          draw_fail;
    logic          hit;
    logic          last_idx;
    logic [31:0]   len_req;
    logic [31:0]   len_clamp;

    // Playfield cells: rows 1..8, columns 2..9 of the decimal code.
    function automatic logic code_ok(input logic [7:0] code);
        logic [7:0] row;
        logic [7:0] col;
        row = code / 8'd10;
        col = code % 8'd10;
        return (row >= 8'd1) && (row <= 8'd8) && (col >= 8'd2);
    endfunction

    assign len_req   = 32'(bus.snake_len);
    assign len_clamp = (len_req > MAX_LEN) ? MAX_LEN : len_req;
    assign hit       = cmp_v_q && (bus.body_rd_data == cand_q);
    assign last_idx  = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        retry_d      = retry_q;
        cand_d       = cand_q;
        idx_d        = idx_q;
        cmp_v_d      = 1'b0;
        food_pos_d   = food_pos_q;
        food_valid_d = food_valid_q;
        busy_d       = busy_q;
        place_fail_d = 1'b0;
        draw_fail    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.place_req) begin
                    len_d        = LW'(len_clamp);
                    retry_d      = '0;
                    food_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = SAMPLE;
                end
            end
            SAMPLE: begin
                cand_d = bus.rnd_num;
                if (!code_ok(bus.rnd_num)) begin
                    draw_fail = 1'b1;
                end else if (len_q == '0) begin
                    food_pos_d   = bus.rnd_num;
                    food_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = DONE;
                end else begin
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                // The address issued this cycle returns data next cycle.
                if (hit) begin
                    draw_fail = 1'b1;
                end else begin
                    cmp_v_d = 1'b1;
                    if (last_idx) begin
                        state_d = TAIL;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            TAIL: begin
                if (hit) begin
                    draw_fail = 1'b1;
                end else begin
                    food_pos_d   = cand_q;
                    food_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (draw_fail) begin
            if (retry_q == RW'(MAX_RETRY - 1)) begin
                place_fail_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end else begin
                retry_d = retry_q + RW'(1);
                state_d = SAMPLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            retry_q      <= '0;
            cand_q       <= '0;
            idx_q        <= '0;
            cmp_v_q      <= 1'b0;
            food_pos_q   <= 8'd55;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            place_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            retry_q      <= retry_d;
            cand_q       <= cand_d;
            idx_q        <= idx_d;
            cmp_v_q      <= cmp_v_d;
            food_pos_q   <= food_pos_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            place_fail_q <= place_fail_d;
        end
    end

    assign bus.body_rd_addr = (state_q == SCAN) ? idx_q : '0;
    assign bus.food_pos     = food_pos_q;
    assign bus.food_valid   = food_valid_q;
    assign bus.busy         = busy_q;
    assign bus.place_fail   = place_fail_q;
endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: each request pushes its expected outcome,
// the output monitor pops and compares when a placement or failure appears.
module tb_food_placer;
    localparam int unsigned MAX_LEN   = 32;
    localparam int unsigned MAX_RETRY = 4;

    typedef struct {
        string      tag;
        logic [7:0] pos;
        logic       fail;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    food_placer_if #(.MAX_LEN(MAX_LEN)) bus();

    food_placer #(.MAX_LEN(MAX_LEN), .MAX_RETRY(MAX_RETRY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [MAX_LEN];
    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         req_cyc = 0;
    logic       prev_valid = 1'b0;

    always @(posedge clk) bus.body_rd_data <= mem[bus.body_rd_addr];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ((bus.food_valid && !prev_valid) || bus.place_fail)) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_pos"},   32'(bus.food_pos),   32'(e.pos));
                check({e.tag, "_fail"},  32'(bus.place_fail), 32'(e.fail));
                check({e.tag, "_valid"}, 32'(bus.food_valid), 32'(!e.fail));
                check({e.tag, "_lat"},   32'(cyc - req_cyc),  32'(e.lat));
                check({e.tag, "_busy"},  32'(bus.busy),       32'd0);
            end
        end
        prev_valid = bus.food_valid;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_req(input string tag, input logic [7:0] pos, input logic fail, input int lat);
        exp_t e;
        e.tag  = tag;
        e.pos  = pos;
        e.fail = fail;
        e.lat  = lat;
        sb.push_back(e);
        bus.place_req = 1'b1;
        tick();
        bus.place_req = 1'b0;
        req_cyc = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            check({tag, "_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pos"},   32'(bus.food_pos),     32'd55);
        check({tag, "_valid"}, 32'(bus.food_valid),   32'd0);
        check({tag, "_busy"},  32'(bus.busy),         32'd0);
        check({tag, "_fail"},  32'(bus.place_fail),   32'd0);
        check({tag, "_addr"},  32'(bus.body_rd_addr), 32'd0);
    endtask

    task automatic clear_mem();
        for (int unsigned i = 0; i < MAX_LEN; i++) mem[i] = 8'hFF;
    endtask

    initial begin
        rst           = 1'b1;
        bus.place_req = 1'b0;
        bus.snake_len = '0;
        bus.rnd_num   = '0;
        clear_mem();
        tick();
        tick();
        check_reset_vals("reset");
        rst = 1'b0;
        tick();

        // T4: candidate always on the body, retry limit exhausted
        mem[0]        = 8'd24;
        bus.snake_len = 6'd1;
        bus.rnd_num   = 8'd24;
        do_req("t4", 8'd55, 1'b1, 12);
        wait_done("t4", 30);
        check("t4_fail_pulse", 32'(bus.place_fail), 32'd0);
        check("t4_pos_hold",   32'(bus.food_pos),   32'd55);
        check("t4_valid_low",  32'(bus.food_valid), 32'd0);

        // T1: empty snake, placed on the first sample edge
        clear_mem();
        bus.snake_len = 6'd0;
        bus.rnd_num   = 8'd45;
        do_req("t1", 8'd45, 1'b0, 1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_addr", 32'(bus.body_rd_addr), 32'd0);
        wait_done("t1", 10);

        // T2: three segments scanned, entry beyond the length must be ignored
        mem[0] = 8'd23;
        mem[1] = 8'd24;
        mem[2] = 8'd25;
        mem[3] = 8'd57;
        bus.snake_len = 6'd3;
        bus.rnd_num   = 8'd57;
        do_req("t2", 8'd57, 1'b0, 5);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t2_addr%0d", i), 32'(bus.body_rd_addr), 32'(i));
        end
        wait_done("t2", 20);

        // T3: first draw hits segment 1, second draw is clear
        bus.rnd_num = 8'd24;
        do_req("t3", 8'd66, 1'b0, 9);
        tick();
        bus.rnd_num = 8'd66;
        wait_done("t3", 20);

        // T5: three off-board codes before a valid one
        bus.snake_len = 6'd0;
        bus.rnd_num   = 8'd10;
        do_req("t5", 8'd47, 1'b0, 4);
        tick();
        bus.rnd_num = 8'd95;
        tick();
        bus.rnd_num = 8'd31;
        tick();
        bus.rnd_num = 8'd47;
        wait_done("t5", 20);

        // Length above MAX_LEN clamps to a full 32-segment scan
        clear_mem();
        bus.snake_len = 6'd40;
        bus.rnd_num   = 8'd88;
        do_req("clamp", 8'd88, 1'b0, 34);
        wait_done("clamp", 60);

        // T6a: request while busy is ignored
        mem[0] = 8'd23;
        mem[1] = 8'd24;
        mem[2] = 8'd25;
        bus.snake_len = 6'd3;
        bus.rnd_num   = 8'd57;
        do_req("t6_ign", 8'd57, 1'b0, 5);
        tick();
        tick();
        bus.place_req = 1'b1;
        bus.rnd_num   = 8'd24;
        tick();
        bus.place_req = 1'b0;
        wait_done("t6_ign", 20);

        // T6b: reset mid-scan aborts with no placement
        bus.rnd_num   = 8'd57;
        bus.place_req = 1'b1;
        tick();
        bus.place_req = 1'b0;
        tick();
        tick();
        check("t6_scan_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        check_reset_vals("t6_rst");
        rst = 1'b0;
        repeat (8) tick();
        check("t6_post_rst_busy", 32'(bus.busy), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
